// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate sweep controller: FSM state encoding and
// truth tables of common 2-input gates (bit i = output for input vector i).
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] XOR_TT  = 4'b0110;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that measures how long the gate inputs have been
// held. zero_o is high once the count has run out.
module settle_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a load wins over a decrement; the counter stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for one combinational gate: steps the gate inputs
// through every vector in ascending order, samples the output after a settle
// interval, compares against the expected truth table and reports the result.
module gate_sweep_ctrl
  import gate_test_pkg::*;
#(
  parameter int unsigned           N_IN     = 2,
  parameter int unsigned           SETTLE   = 1,
  parameter logic [2**N_IN-1:0]    EXPECTED = NAND_TT
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  output logic [N_IN-1:0]      dut_in_o,
  input  logic                 dut_out_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [2**N_IN-1:0]   result_o,
  output logic [N_IN:0]        err_count_o,
  output logic [N_IN-1:0]      first_err_o,
  output logic                 first_err_valid_o
);

  localparam int unsigned      N_VEC       = 2**N_IN;
  localparam int unsigned      TW          = $clog2(SETTLE + 1);
  localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_IDX    = N_IN'(N_VEC - 1);

  state_e                state_q, state_d;
  logic [N_IN-1:0]       idx_q, idx_d;
  logic [N_IN-1:0]       dut_in_q, dut_in_d;
  logic [N_VEC-1:0]      result_q, result_d;
  logic [N_IN:0]         err_count_q, err_count_d;
  logic [N_IN-1:0]       first_err_q, first_err_d;
  logic                  first_err_valid_q, first_err_valid_d;
  logic                  pass_q, pass_d;
  logic                  timer_load;
  logic                  timer_dec;
  logic                  timer_zero;

  // Settle counter: loaded with SETTLE-1 on DRIVE entry so DRIVE lasts
  // exactly SETTLE cycles.
  settle_timer #(
    .W (TW)
  ) u_settle_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (timer_load),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  // Next-state and datapath update for the sweep sequence.
  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d           = state_q;
    idx_d             = idx_q;
    dut_in_d          = dut_in_q;
    result_d          = result_q;
    err_count_d       = err_count_q;
    first_err_d       = first_err_q;
    first_err_valid_d = first_err_valid_q;
    pass_d            = pass_q;
    timer_load        = 1'b0;
    timer_dec         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d           = ST_DRIVE;
          idx_d             = '0;
          dut_in_d          = '0;
          result_d          = '0;
          err_count_d       = '0;
          first_err_d       = '0;
          first_err_valid_d = 1'b0;
          pass_d            = 1'b0;
          timer_load        = 1'b1;
        end
      end

      ST_DRIVE: begin
        if (timer_zero) state_d   = ST_SAMPLE;
        else            timer_dec = 1'b1;
      end

      ST_SAMPLE: begin
        result_d[idx_q] = dut_out_i;
        if (dut_out_i != EXPECTED[idx_q]) begin
          err_count_d = err_count_q + (N_IN + 1)'(1);
          if (!first_err_valid_q) begin
            first_err_d       = idx_q;
            first_err_valid_d = 1'b1;
          end
        end
        if (idx_q == LAST_IDX) begin
          // pass uses the count including this final sample, so it is
          // valid in the same cycle as done.
          state_d = ST_DONE;
          pass_d  = (err_count_d == '0);
        end else begin
          state_d    = ST_DRIVE;
          idx_d      = idx_q + N_IN'(1);
          dut_in_d   = idx_q + N_IN'(1);
          timer_load = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any sweep in progress.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of order.
    if (reset_i) begin
      state_q           <= ST_IDLE;
      idx_q             <= '0;
      dut_in_q          <= '0;
      result_q          <= '0;
      err_count_q       <= '0;
      first_err_q       <= '0;
      first_err_valid_q <= 1'b0;
      pass_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      dut_in_q          <= dut_in_d;
      result_q          <= result_d;
      err_count_q       <= err_count_d;
      first_err_q       <= first_err_d;
      first_err_valid_q <= first_err_valid_d;
      pass_q            <= pass_d;
    end
  end

  assign dut_in_o          = dut_in_q;
  assign busy_o            = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done_o            = (state_q == ST_DONE);
  assign pass_o            = pass_q;
  assign result_o          = result_q;
  assign err_count_o       = err_count_q;
  assign first_err_o       = first_err_q;
  assign first_err_valid_o = first_err_valid_q;

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Self-test sequencer for a single combinational gate under test (default: the 2-input Nand).
- On start, walks dut_in through every input combination in ascending order.
- For each vector: waits a settle interval, samples dut_out, and compares it with an expected truth table.
- Reports the captured table, mismatch count, first failing vector and pass/fail.
- Sits between a board-level start button/host strobe and the gate instance; replaces hand-written truth-table benches on hardware.

Parameters:
- N_IN, 2: number of gate inputs; the sweep covers 2**N_IN vectors.
- SETTLE, 1: cycles dut_in is held before sampling; legal range ≥1.
- EXPECTED, 4'b0111: expected truth table, width 2**N_IN; bit i = expected dut_out for dut_in==i. The default is Nand.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: sweep request; sampled only in IDLE.
- dut_in, out, N_IN: drive to gate inputs; bit 0 = LSB input (b for Nand, a = bit 1).
- dut_out, in, 1: gate output.
- busy, out, 1: high from the cycle after start is accepted through the last SAMPLE cycle.
- done, out, 1: one-cycle pulse after the last sample.
- pass, out, 1: err_count==0 for the last completed sweep.
- result, out, 2**N_IN: captured dut_out per vector.
- err_count, out, N_IN+1: number of mismatching vectors.
- first_err, out, N_IN: lowest mismatching vector index.
- first_err_valid, out, 1: at least one mismatch recorded.

Behaviour:
- Reset values: state=IDLE, dut_in=0, busy=0, done=0, pass=0, result=0, err_count=0, first_err=0, first_err_valid=0, internal idx=0, settle count=0.
- Reset mid-sweep: same as above on the next edge; the partial sweep is discarded and no done pulse is issued.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 → DRIVE.
  - At the same edge: idx=0, dut_in=0, clear result, err_count, first_err, first_err_valid and pass, and load settle count.
- DRIVE:
  - dut_in=idx, held for exactly SETTLE cycles, then → SAMPLE.
- SAMPLE (1 cycle):
  - At the closing edge: result[idx]=dut_out.
  - If dut_out≠EXPECTED[idx]: err_count+1; if first_err_valid=0, set first_err=idx and first_err_valid=1.
  - If idx==2**N_IN-1 → DONE; otherwise idx+1, dut_in=idx+1, reload settle count, → DRIVE.
- DONE (1 cycle):
  - done=1, busy=0.
  - pass registered as (err_count==0) at the entering edge, so it is valid in the same cycle as done.
  - → IDLE.
- Timing: start high in cycle 0 → busy in cycles 1..2**N_IN*(SETTLE+1) → done in cycle 2**N_IN*(SETTLE+1)+1.
- dut_in changes only on DRIVE entry, never during SAMPLE.
- Results and pass hold their values in IDLE until the next accepted start.
- start during DRIVE, SAMPLE or DONE is ignored, not queued. start held high re-triggers a new sweep from IDLE.
- err_count cannot overflow: its width N_IN+1 holds 2**N_IN.
- idx does not wrap; the terminal compare forces DONE.

Decomposition:
- Shared package/include `gate_test_pkg`:
  - FSM state encodings (2-bit).
  - Truth-table constants: NAND_TT=4'b0111, AND_TT=4'b1000, OR_TT=4'b1110, XOR_TT=4'b0110.
- One natural sub-module, `settle_timer`: a loadable down-counter with load, width $clog2(SETTLE+1), and a zero flag. Its wrapper instantiates gate_sweep_ctrl with Nand.

Test Plan:
1. Real Nand, N_IN=2, SETTLE=1, start pulse in cycle 0 → dut_in sequence 0,0,1,1,2,2,3,3 in cycles 1-8; done in cycle 9; result=4'b0111, err_count=0, pass=1, first_err_valid=0.
2. dut_out stuck at 1 → result=4'b1111, err_count=1, first_err=3, first_err_valid=1, pass=0.
3. dut_out stuck at 0 → result=4'b0000, err_count=3, first_err=0, pass=0.
4. start re-pulsed in cycles 3 and 9 (DRIVE and DONE) → ignored; exactly one done pulse in cycle 9; no dut_in disturbance.
5. reset asserted in cycle 4 mid-sweep → next cycle all outputs at reset values, no done; a new start yields a full correct sweep, done 9 cycles later.
6. SETTLE=3, good Nand → each vector held 4 cycles; done in cycle 17; pass=1.
